signed_digit_serializer: RTL and testbench

SIGNED_DIGIT_SERIALIZER -- requirements
Module: signed_digit_serializer

---
 rtl/signed_digit_serializer.sv | 92 +++++++++
 tb/tb_signed_digit_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_digit_serializer.sv
// rtl/signed_digit_serializer.sv - serializes a two's-complement word into Booth-recoded signed digits, MSD first
// One digit per q transfer; a new word may be accepted on the last digit's transfer for gapless streaming.
module signed_digit_serializer #(
    parameter int no_of_digits = 8,
    parameter int radix_bits   = 3,
    localparam int W = no_of_digits * (radix_bits - 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [radix_bits-1:0] q,
    output logic                  q_valid,
    input  logic                  q_ready,
    output logic                  q_first,
    output logic                  q_last,
    output logic                  busy
);

    localparam int K  = radix_bits - 1;
    localparam int CW = (no_of_digits > 1) ? $clog2(no_of_digits) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(no_of_digits - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W:0]      sr_q, sr_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic            emit;
    logic            accept;
    logic signed [radix_bits-1:0] digit;

    // Window of K+1 bits: upper K bits as a signed value plus the borrowed bit below.
    assign digit = $signed({sr_q[W], sr_q[W -: K]}) + $signed({{K{1'b0}}, sr_q[W-K]});

    assign emit      = (state_q == EMIT);
    assign q_valid   = emit;
    assign busy      = emit;
    assign q_first   = emit && (idx_q == LAST_IDX);
    assign q_last    = emit && (idx_q == '0);
    assign q         = emit ? digit : '0;
    assign din_ready = !reset && (!emit || (q_last && q_ready));
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                    sr_d    = {din, 1'b0};
                    idx_d   = LAST_IDX;
                end
            end
            EMIT: begin
                if (q_ready) begin
                    if (idx_q == '0) begin
                        if (accept) begin
                            sr_d  = {din, 1'b0};
                            idx_d = LAST_IDX;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sr_d  = {sr_q[W-K:0], {K{1'b0}}};
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_signed_digit_serializer.sv
// tb/tb_signed_digit_serializer.sv - self-checking bench for signed_digit_serializer
// Fixed vectors, randomized words with stalls, back-to-back and mid-word reset sequences.
module tb_signed_digit_serializer;

    localparam int N  = 8;
    localparam int RB = 3;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  din;
    logic          din_valid;
    logic          din_ready;
    logic [RB-1:0] q;
    logic          q_valid;
    logic          q_ready;
    logic          q_first;
    logic          q_last;
    logic          busy;

    int total = 0;
    int bad   = 0;

    typedef int digs_t [N];
    typedef struct packed {
        logic [W-1:0]           din;
        logic [N-1:0][RB-1:0]   exp;
    } vec_t;

    signed_digit_serializer #(.no_of_digits(N), .radix_bits(RB)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .q(q), .q_valid(q_valid), .q_ready(q_ready), .q_first(q_first), .q_last(q_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: digit i from the word's bits per the recoding rule, x[-1] = 0.
    function automatic digs_t model(input logic [W-1:0] w);
        digs_t d;
        int xm1;
        for (int i = 0; i < N; i++) begin
            xm1  = (i == 0) ? 0 : int'(w[2*i-1]);
            d[i] = -2 * int'(w[2*i+1]) + int'(w[2*i]) + xm1;
        end
        return d;
    endfunction

    function automatic longint digs_value(input digs_t d);
        longint s = 0;
        for (int i = N - 1; i >= 0; i--) s = s * 4 + longint'(d[i]);
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offers w until accepted, then checks the MSD appears one cycle later.
    task automatic send_word(input logic [W-1:0] w);
        int cyc = 0;
        din = w;
        din_valid = 1'b1;
        q_ready = 1'b1;
        #1;
        while (!din_ready && cyc < 50) begin
            tick();
            #1;
            cyc++;
        end
        chk("accept_timeout", int'(din_ready), 1);
        tick();
        din_valid = 1'b0;
        din = W'($urandom);
        #1;
        chk("latency_q_valid", int'(q_valid), 1);
        chk("latency_q_first", int'(q_first), 1);
    endtask

    // Drains one word; with stall set, q_ready toggles randomly and din_valid carries junk that must be ignored.
    task automatic collect(input bit stall, output digs_t got);
        int n = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [RB-1:0] hq;
        logic hf, hl;
        for (int i = 0; i < N; i++) got[i] = 99;
        while (n < N && cyc < 400) begin
            q_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            din_valid = (stall && n != N - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            din = W'($urandom);
            #1;
            if (held) begin
                chk("stall_q_hold", int'(q), int'(hq));
                chk("stall_first_hold", int'(hf), int'(q_first));
                chk("stall_last_hold", int'(hl), int'(q_last));
                held = 1'b0;
            end
            if (!stall) chk("throughput_q_valid", int'(q_valid), 1);
            if (q_valid) begin
                chk("q_first_pos", int'(q_first), int'(n == 0));
                chk("q_last_pos", int'(q_last), int'(n == N - 1));
                chk("busy_emit", int'(busy), 1);
                if (q_ready) begin
                    got[N-1-n] = int'($signed(q));
                    n++;
                end else begin
                    held = 1'b1;
                    hq = q;
                    hf = q_first;
                    hl = q_last;
                end
            end
            tick();
            cyc++;
        end
        chk("collect_digit_count", n, N);
        din_valid = 1'b0;
        q_ready = 1'b0;
    endtask

    task automatic cmp_digs(input string name, input digs_t got, input digs_t exp);
        for (int i = N - 1; i >= 0; i--) chk(name, got[i], exp[i]);
    endtask

    vec_t  vecs [6];
    digs_t got, ref_d, ref_b;
    logic [W-1:0] w, w2;
    logic signed [RB-1:0] e;

    initial begin
        vecs[0] = '{16'h7FFF, {3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111}};
        vecs[1] = '{16'h8000, {3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000}};
        vecs[2] = '{16'hFFFF, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111}};
        vecs[3] = '{16'h0000, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000}};
        vecs[4] = '{16'h0001, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001}};
        vecs[5] = '{16'h0002, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b110}};

        reset = 1'b1;
        din = '0;
        din_valid = 1'b0;
        q_ready = 1'b0;
        tick();
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("reset_q_valid", int'(q_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_din_ready", int'(din_ready), 1);
        chk("reset_q", int'(q), 0);
        chk("reset_q_first", int'(q_first), 0);
        chk("reset_q_last", int'(q_last), 0);
        tick();

        foreach (vecs[v]) begin
            send_word(vecs[v].din);
            collect(1'b0, got);
            for (int i = 0; i < N; i++) begin
                e = vecs[v].exp[i];
                chk($sformatf("vec%0d_digit%0d", v, i), got[i], int'(e));
            end
            #1;
            chk("idle_after_word", int'(q_valid), 0);
            tick();
        end

        for (int r = 0; r < 25; r++) begin
            w = W'($urandom);
            if (r == 0) w = 16'h8000;
            send_word(w);
            collect(1'b1, got);
            cmp_digs("rand_digit", got, model(w));
            chk("rand_value", int'(digs_value(got)), int'($signed(w)));
        end

        // Back-to-back: second word accepted on the last digit transfer.
        w  = W'($urandom);
        w2 = W'($urandom);
        ref_d = model(w);
        ref_b = model(w2);
        send_word(w);
        for (int i = 0; i < N - 1; i++) begin
            q_ready = 1'b1;
            #1;
            chk("b2b_first_digits", int'($signed(q)), ref_d[N-1-i]);
            tick();
        end
        q_ready = 1'b1;
        din = w2;
        din_valid = 1'b1;
        #1;
        chk("b2b_last_flag", int'(q_last), 1);
        chk("b2b_din_ready", int'(din_ready), 1);
        chk("b2b_lsd", int'($signed(q)), ref_d[0]);
        tick();
        din_valid = 1'b0;
        #1;
        chk("b2b_q_valid", int'(q_valid), 1);
        chk("b2b_q_first", int'(q_first), 1);
        collect(1'b0, got);
        cmp_digs("b2b_second_word", got, ref_b);

        // Reset after three digits transferred.
        tick();
        w = 16'h7FFF;
        send_word(w);
        q_ready = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_ready = 1'b0;
        #1;
        chk("midreset_q_valid", int'(q_valid), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_din_ready", int'(din_ready), 1);
        chk("midreset_q_first", int'(q_first), 0);
        tick();
        w2 = 16'h1234;
        send_word(w2);
        collect(1'b0, got);
        cmp_digs("after_reset_word", got, model(w2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
